// File: rtl/lfsr_rr_server.sv
// Round-robin server that hands out 4-bit Fibonacci LFSR values, one grant per cycle.
// Optional build macro LFSR_SRV_STATS_EN adds a saturating SERVE-cycle counter on grant_cnt_o.
module lfsr_rr_server #(
  parameter int         NREQ = 4,
  parameter logic [3:0] SEED = 4'hF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            seed_ld_i,
  input  logic [3:0]      seed_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o,
  output logic [3:0]      data_o,
`ifdef LFSR_SRV_STATS_EN
  output logic [7:0]      grant_cnt_o,
`endif
  output logic            dbg_state_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: valid_o is high exactly in SERVE cycles; gnt_o names the one
  // requester served and data_o carries its value. There is no ready -- a
  // requester must accept in the cycle valid_o is high.
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      data_q, data_d;
  logic [3:0]      lfsr_q, lfsr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] eligible;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;

  function automatic logic [PW-1:0] wrap_add(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Whoever holds the grant this cycle sits out the next arbitration.
  always_comb begin
    eligible = req_i & ~gnt_q;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && eligible[wrap_add(int'(ptr_q), i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(int'(ptr_q), i);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      data_q  <= 4'h0;
      lfsr_q  <= SEED;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (enable_i && pick_vld) ? SERVE : IDLE;
      SERVE:   state_d = (enable_i && pick_vld) ? SERVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. The LFSR steps at the end of every SERVE cycle;
  // a reseed overrides that step, and a zero seed falls back to SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_ld_i)
      lfsr_d = (seed_i == 4'h0) ? SEED : seed_i;
    else if (state_q == SERVE)
      lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

    gnt_d  = '0;
    ptr_d  = ptr_q;
    data_d = data_q;
    if (state_d == SERVE) begin
      gnt_d[pick_idx] = 1'b1;
      ptr_d           = wrap_add(int'(pick_idx), 1);
      data_d          = lfsr_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign valid_o     = (state_q == SERVE);
  assign data_o      = data_q;
  assign dbg_state_o = state_q;

`ifdef LFSR_SRV_STATS_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= 8'h00;
    else if (state_q == SERVE && cnt_q != 8'hFF)
      cnt_q <= cnt_q + 8'h01;
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Directed bench for lfsr_rr_server; expected outputs queue up as each step is driven.
// Define LFSR_SRV_STATS_EN to also exercise grant_cnt_o.
module tb_lfsr_rr_server;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] req = 4'h0;
  logic       seed_ld = 1'b0;
  logic [3:0] seed = 4'h0;
  logic [3:0] gnt;
  logic       valid;
  logic [3:0] data;
  logic       dbg_state;
`ifdef LFSR_SRV_STATS_EN
  logic [7:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  lfsr_rr_server #(.NREQ(4), .SEED(4'hF)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .req_i       (req),
    .seed_ld_i   (seed_ld),
    .seed_i      (seed),
    .gnt_o       (gnt),
    .valid_o     (valid),
    .data_o      (data),
`ifdef LFSR_SRV_STATS_EN
    .grant_cnt_o (grant_cnt),
`endif
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, then compare after the edge.
  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic sl, input logic [3:0] sd,
                      input logic ev, input logic [3:0] eg, input logic [3:0] ed);
    logic [8:0] item;
    rst = r; enable = e; req = rq; seed_ld = sl; seed = sd;
    exp_q.push_back({ev, eg, ed});
    @(posedge clk);
    #1;
    item = exp_q.pop_front();
    check("valid", 8'(valid), 8'(item[8]));
    check("gnt", 8'(gnt), 8'(item[7:4]));
    if (item[8] || r) check("data", 8'(data), 8'(item[3:0]));
  endtask

  initial begin
    // Reset state
    step(1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0);
    // Single requester held: grant every second cycle, F E C 8 1 2
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'hF);
    step(0, 1, 4'b0001, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'hE);
    step(0, 1, 4'b0001, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'hC);
    step(0, 1, 4'b0001, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'h8);
    step(0, 1, 4'b0001, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'h1);
    step(0, 1, 4'b0001, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'h2);
    step(0, 1, 4'b0000, 0, 4'h0, 0, 4'b0000, 4'h0);

    // All requesting from reset: rotate every cycle
    step(1, 1, 4'b1111, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0001, 4'hF);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0010, 4'hE);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0100, 4'hC);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b1000, 4'h8);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0001, 4'h1);
    // Enable low: grants stop, LFSR frozen, resume without skip
    step(0, 0, 4'b1111, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 0, 4'b1111, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0010, 4'h2);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0100, 4'h4);
    step(0, 1, 4'b0000, 0, 4'h0, 0, 4'b0000, 4'h0);

    // Zero seed falls back to SEED; pointer wraps from 3 to 0
    step(0, 1, 4'b0000, 1, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'hF);
    step(0, 1, 4'b0000, 0, 4'h0, 0, 4'b0000, 4'h0);
    // Seed 9 then 3
    step(0, 1, 4'b0000, 1, 4'h9, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0010, 0, 4'h0, 1, 4'b0010, 4'h9);
    step(0, 1, 4'b0100, 0, 4'h0, 1, 4'b0100, 4'h3);
    // Reseed during SERVE overrides the advance: 5 then B
    step(0, 1, 4'b1000, 1, 4'h5, 1, 4'b1000, 4'h5);
    step(0, 1, 4'b0001, 0, 4'h0, 1, 4'b0001, 4'hB);
    // Reseed honoured with enable low, while the last SERVE completes
    step(0, 0, 4'b0000, 1, 4'h9, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0010, 0, 4'h0, 1, 4'b0010, 4'h9);

    // Reset mid-SERVE drops the grant; restart at req1 with SEED
    step(1, 1, 4'b0110, 0, 4'h0, 0, 4'b0000, 4'h0);
    step(0, 1, 4'b0110, 0, 4'h0, 1, 4'b0010, 4'hF);
    step(0, 1, 4'b0110, 0, 4'h0, 1, 4'b0100, 4'hE);
    step(0, 1, 4'b0000, 0, 4'h0, 0, 4'b0000, 4'h0);

`ifdef LFSR_SRV_STATS_EN
    step(1, 1, 4'b0000, 0, 4'h0, 0, 4'b0000, 4'h0);
    check("cnt_reset", grant_cnt, 8'h00);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0001, 4'hF);
    check("cnt_first", grant_cnt, 8'h00);
    step(0, 1, 4'b1111, 0, 4'h0, 1, 4'b0010, 4'hE);
    check("cnt_second", grant_cnt, 8'h01);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
    end
    #1;
    check("cnt_sat", grant_cnt, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
    end
    #1;
    check("cnt_hold", grant_cnt, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_server.md
LFSR_RR_SERVER -- requirements
Module: lfsr_rr_server

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter SEED, default 4'hF, LFSR reset/fallback value (nonzero).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable_i  input  1  permits new grants and LFSR advance when high.
REQ-006 SHALL have port req_i  input  NREQ  per-requester level request for one random value.
REQ-007 SHALL have port seed_ld_i  input  1  one-cycle strobe, load seed_i into LFSR.
REQ-008 SHALL have port seed_i  input  4  reseed value.
REQ-009 SHALL have port gnt_o  output  NREQ  registered one-hot grant; all-zero when no grant.
REQ-010 SHALL have port valid_o  output  1  registered; high exactly when gnt_o is nonzero.
REQ-011 SHALL have port data_o  output  4  registered random value, meaningful only while valid_o is high.

Function
REQ-012 SHALL hold a 4-bit Fibonacci LFSR: on advance, bits [3:1] take old [2:0], bit 0 takes old bit3 XOR old bit2 (period 15 from any nonzero state).
REQ-013 SHALL implement FSM states IDLE (no grant) and SERVE (grant driven this cycle).
REQ-014 IDLE -> SERVE when enable_i high and any eligible req_i bit high at the clock edge; otherwise stay IDLE.
REQ-015 SERVE -> SERVE when enable_i high and another eligible request exists; SERVE -> IDLE otherwise.
REQ-016 Eligibility: a requester granted in the current cycle SHALL NOT be eligible at the edge ending that cycle (max one grant per two cycles per requester).
REQ-017 Arbitration SHALL be round-robin: search starts at index one above the last granted index, wrapping from NREQ-1 to 0; after reset search starts at index 0.
REQ-018 Latency: request sampled at edge N SHALL produce gnt_o/valid_o/data_o in the cycle after edge N; back-to-back grants to different requesters SHALL be possible every cycle.
REQ-019 data_o in a SERVE cycle SHALL equal the LFSR state; the LFSR SHALL advance at the edge ending every SERVE cycle, so no two consecutive grants receive the same value.
REQ-020 enable_i low SHALL freeze the LFSR and block new grants; a SERVE cycle already in progress completes unchanged.
REQ-021 seed_ld_i SHALL load seed_i at the next edge, overriding the advance; a grant in that cycle still delivers the pre-load value.
REQ-022 seed_i of 4'h0 SHALL be replaced by SEED to avoid the all-zero lockup state.
REQ-023 seed_ld_i is honoured regardless of enable_i and FSM state.

Reset
REQ-024 rst_i high at an edge SHALL set LFSR to SEED, FSM to IDLE, gnt_o to 0, valid_o to 0, data_o to 4'h0, round-robin pointer to index 0, overriding seed_ld_i and requests.
REQ-025 Reset mid-SERVE SHALL drop the grant in the following cycle; no partial state survives.

Configuration
REQ-026 With macro LFSR_SRV_STATS_EN defined, SHALL add output grant_cnt_o [7:0]: count of SERVE cycles since reset, saturating at 8'hFF, reset to 0.
REQ-027 Without LFSR_SRV_STATS_EN, port grant_cnt_o and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, then req_i=4'b0001 held, enable_i=1 -> grants to req0 every second cycle with data_o F, E, C, 8, 1, 2, ...
REQ-029 req_i=4'b1111 held from reset -> gnt_o cycles 0001, 0010, 0100, 1000, 0001 on consecutive cycles, data_o F, E, C, 8, 1.
REQ-030 seed_ld_i=1, seed_i=4'h0 while idle -> next grant data_o = SEED (4'hF); seed_i=4'h9 -> next grant data_o 9, following 3.
REQ-031 enable_i driven low during continuous requests -> grants stop within one cycle, LFSR frozen; re-enable resumes sequence without skip.
REQ-032 rst_i asserted during SERVE with req_i=4'b0110 -> next cycle gnt_o=0, valid_o=0; first post-reset grant goes to req1 with data_o 4'hF.
REQ-033 LFSR_SRV_STATS_EN build, 300 continuous grants -> grant_cnt_o reads 8'hFF and holds.
